// File: rtl/bfm_ahb_rr_master_if.sv
// Command and AHB-Lite signal bundle for the round-robin AHB master.
// The master view belongs to the scheduler. The slave view belongs to the
// environment, meaning the command sources together with the AHB slave.
interface bfm_ahb_rr_master_if #(
  parameter int NREQ = 4
);
  // requester side
  logic [NREQ-1:0]      REQ;
  logic [NREQ-1:0]      REQ_WRITE;
  logic [32*NREQ-1:0]   REQ_ADDR;
  logic [32*NREQ-1:0]   REQ_WDATA;
  logic [NREQ-1:0]      GRANT;
  logic [NREQ-1:0]      ACK;
  logic [31:0]          RDATA;
  logic                 ERR;
  // AHB-Lite side
  logic                 HSEL;
  logic [31:0]          HADDR;
  logic                 HWRITE;
  logic [1:0]           HTRANS;
  logic [2:0]           HSIZE;
  logic [2:0]           HBURST;
  logic                 HMASTLOCK;
  logic [3:0]           HPROT;
  logic [31:0]          HWDATA;
  logic [31:0]          HRDATA;
  logic                 HREADY;
  logic                 HRESP;

  modport master (
    input  REQ, REQ_WRITE, REQ_ADDR, REQ_WDATA, HRDATA, HREADY, HRESP,
    output GRANT, ACK, RDATA, ERR, HSEL, HADDR, HWRITE, HTRANS, HSIZE,
           HBURST, HMASTLOCK, HPROT, HWDATA
  );

  modport slave (
    output REQ, REQ_WRITE, REQ_ADDR, REQ_WDATA, HRDATA, HREADY, HRESP,
    input  GRANT, ACK, RDATA, ERR, HSEL, HADDR, HWRITE, HTRANS, HSIZE,
           HBURST, HMASTLOCK, HPROT, HWDATA
  );
endinterface

// File: rtl/bfm_ahb_rr_master.sv
// Round-robin scheduler that shares one AHB-Lite slave between NREQ
// single-word command requesters. It runs one non-pipelined transfer per grant.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   IDLE    | no owner; pick the next requester above LAST, latch its command
//   ADDR    | address phase (HSEL=1, NONSEQ), wait for HREADY
//   DATA    | data phase, HWDATA driven; capture HRDATA/HRESP on HREADY
//   DONE    | one-cycle ACK to the owner, then release the grant
//
// NREQ on the module must match NREQ on the connected interface.
module bfm_ahb_rr_master #(
  parameter int NREQ = 4
) (
  input logic                 HCLK,
  input logic                 HRESET,
  bfm_ahb_rr_master_if.master bus
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [IW-1:0] LAST_RST = IW'(NREQ - 1);
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA, ST_DONE} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   last_q, last_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            err_q, err_d;
  logic            hsel_q, hsel_d;
  logic [31:0]     haddr_q, haddr_d;
  logic            hwrite_q, hwrite_d;
  logic [1:0]      htrans_q, htrans_d;
  logic [31:0]     hwdata_q, hwdata_d;

  logic            sel_found;
  logic [IW-1:0]   sel_idx;
  logic [IW-1:0]   cand;

  // Rotating-priority search: the first set REQ bit strictly above the last owner, wrapping.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IW'((int'(last_q) + k) % NREQ);
      if (!sel_found && bus.REQ[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  // Next-state and registered-output logic; every output holds unless the state says otherwise.
  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    grant_d  = grant_q;
    ack_d    = '0;
    rdata_d  = rdata_q;
    err_d    = err_q;
    hsel_d   = hsel_q;
    haddr_d  = haddr_q;
    hwrite_d = hwrite_q;
    htrans_d = htrans_q;
    hwdata_d = hwdata_q;

    case (state_q)
      ST_IDLE: begin
        if (sel_found) begin
          state_d          = ST_ADDR;
          last_d           = sel_idx;
          grant_d          = '0;
          grant_d[sel_idx] = 1'b1;
          haddr_d          = bus.REQ_ADDR[32*int'(sel_idx) +: 32];
          hwrite_d         = bus.REQ_WRITE[sel_idx];
          hwdata_d         = bus.REQ_WDATA[32*int'(sel_idx) +: 32];
          hsel_d           = 1'b1;
          htrans_d         = HTRANS_NONSEQ;
        end
      end
      ST_ADDR: begin
        if (bus.HREADY) begin
          state_d  = ST_DATA;
          hsel_d   = 1'b0;
          htrans_d = HTRANS_IDLE;
        end
      end
      ST_DATA: begin
        // HREADY low covers both wait states and the first cycle of an error response.
        if (bus.HREADY) begin
          if (!hwrite_q) rdata_d = bus.HRDATA;
          err_d   = bus.HRESP;
          ack_d   = grant_q;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        grant_d = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset aborts any transfer in flight and does not acknowledge it.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q  <= ST_IDLE;
      last_q   <= LAST_RST;
      grant_q  <= '0;
      ack_q    <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      hsel_q   <= 1'b0;
      haddr_q  <= '0;
      hwrite_q <= 1'b0;
      htrans_q <= HTRANS_IDLE;
      hwdata_q <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      grant_q  <= grant_d;
      ack_q    <= ack_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      hsel_q   <= hsel_d;
      haddr_q  <= haddr_d;
      hwrite_q <= hwrite_d;
      htrans_q <= htrans_d;
      hwdata_q <= hwdata_d;
    end
  end

  assign bus.GRANT     = grant_q;
  assign bus.ACK       = ack_q;
  assign bus.RDATA     = rdata_q;
  assign bus.ERR       = err_q;
  assign bus.HSEL      = hsel_q;
  assign bus.HADDR     = haddr_q;
  assign bus.HWRITE    = hwrite_q;
  assign bus.HTRANS    = htrans_q;
  assign bus.HWDATA    = hwdata_q;
  // single-word, non-burst, unlocked, privileged data access
  assign bus.HSIZE     = 3'b010;
  assign bus.HBURST    = 3'b000;
  assign bus.HMASTLOCK = 1'b0;
  assign bus.HPROT     = 4'b0011;

endmodule

// File: tb/tb_bfm_ahb_rr_master.sv
// Bench for bfm_ahb_rr_master.
// It contains a transaction-level reference model, an AHB slave with a
// programmable number of wait states and an error option, per-requester
// command queues, and directed scenarios with literal expectations.
module tb_bfm_ahb_rr_master;
  localparam int NREQ = 4;
  localparam logic [31:0] JUNK = 32'hBAD0_BAD0;

  logic HCLK = 1'b0;
  logic HRESET;

  bfm_ahb_rr_master_if #(.NREQ(NREQ)) bus ();

  bfm_ahb_rr_master #(.NREQ(NREQ)) dut (
    .HCLK  (HCLK),
    .HRESET(HRESET),
    .bus   (bus.master)
  );

  always #5 HCLK = ~HCLK;

  int cyc = 0;
  always @(posedge HCLK) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
  } cmd_t;

  typedef struct {
    int          idx;
    int          cyc;
    logic        err;
    logic [31:0] rdata;
    logic [31:0] haddr;
    logic [31:0] hwdata;
  } ack_t;

  cmd_t pend[NREQ][$];
  int   req_t[NREQ];
  ack_t alog[$];

  // slave behaviour for the transfer in flight
  int          slv_wait  = 1;
  logic        slv_err   = 1'b0;
  logic [31:0] slv_rdata = 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [NREQ-1:0] onehot(input int i);
    logic [NREQ-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic enq(input int i, input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
    cmd_t c;
    c.wr    = wr;
    c.addr  = addr;
    c.wdata = wdata;
    pend[i].push_back(c);
  endtask

  // AHB slave. It is ready in the address phase. In the data phase it holds
  // HREADY low for slv_wait cycles, and an error response raises HRESP one
  // cycle before HREADY.
  initial begin
    bit dphase;
    int dcnt;
    dphase = 0;
    dcnt   = 0;
    bus.HREADY = 1'b1;
    bus.HRESP  = 1'b0;
    bus.HRDATA = JUNK;
    forever begin
      @(negedge HCLK);
      if (HRESET) begin
        dphase = 0;
        bus.HREADY = 1'b1; bus.HRESP = 1'b0; bus.HRDATA = JUNK;
      end else if (bus.HSEL) begin
        dphase = 1;
        dcnt   = 0;
        bus.HREADY = 1'b1; bus.HRESP = 1'b0; bus.HRDATA = JUNK;
      end else if (dphase) begin
        bus.HREADY = (dcnt == slv_wait);
        bus.HRESP  = slv_err && (dcnt >= slv_wait - 1);
        bus.HRDATA = (dcnt == slv_wait) ? slv_rdata : JUNK;
        if (dcnt == slv_wait) dphase = 0;
        dcnt++;
      end else begin
        bus.HREADY = 1'b1; bus.HRESP = 1'b0; bus.HRDATA = JUNK;
      end
    end
  end

  // Requesters. Each one presents the next queued command and holds it until
  // ACK. It drops REQ on the edge that ends the ACK cycle.
  initial begin
    int   seen;
    cmd_t c;
    seen = 0;
    bus.REQ = '0; bus.REQ_WRITE = '0; bus.REQ_ADDR = '0; bus.REQ_WDATA = '0;
    forever begin
      @(posedge HCLK);
      #1;
      if (HRESET) begin
        bus.REQ = '0;
        seen    = alog.size();
      end else begin
        logic [NREQ-1:0] acked;
        acked = '0;
        while (seen < alog.size()) begin
          acked[alog[seen].idx] = 1'b1;
          seen++;
        end
        for (int i = 0; i < NREQ; i++) begin
          if (acked[i]) begin
            bus.REQ[i] = 1'b0;
          end else if (!bus.REQ[i] && pend[i].size() > 0) begin
            c = pend[i].pop_front();
            bus.REQ[i]               = 1'b1;
            bus.REQ_WRITE[i]         = c.wr;
            bus.REQ_ADDR[32*i +: 32]  = c.addr;
            bus.REQ_WDATA[32*i +: 32] = c.wdata;
            req_t[i]                 = cyc;
          end
        end
      end
    end
  end

  // Reference model and per-cycle compare. A grant decided in the IDLE cycle
  // t appears as follows: address phase at t+1, data phase t+2..t+2+W, ACK at
  // t+3+W, and the next decision at t+4+W.
  initial begin
    int          m_last, m_owner, m_cyc, m_w;
    bit          m_busy;
    logic        m_hwrite, m_err;
    logic [31:0] m_haddr, m_hwdata, m_rdata;
    logic [NREQ-1:0] e_grant, e_ack;
    logic        e_hsel;
    m_last = NREQ - 1; m_busy = 0; m_owner = 0; m_cyc = 0; m_w = 0;
    m_hwrite = 0; m_err = 0; m_haddr = 0; m_hwdata = 0; m_rdata = 0;
    forever begin
      @(negedge HCLK);
      chk("hsize",     32'(bus.HSIZE), 32'h2);
      chk("hburst",    32'(bus.HBURST), 32'h0);
      chk("hmastlock", 32'(bus.HMASTLOCK), 32'h0);
      chk("hprot",     32'(bus.HPROT), 32'h3);
      if (HRESET) begin
        m_last = NREQ - 1; m_busy = 0;
        m_hwrite = 0; m_err = 0; m_haddr = 0; m_hwdata = 0; m_rdata = 0;
        chk("rst_grant",  32'(bus.GRANT), 32'h0);
        chk("rst_ack",    32'(bus.ACK), 32'h0);
        chk("rst_hsel",   32'(bus.HSEL), 32'h0);
        chk("rst_htrans", 32'(bus.HTRANS), 32'h0);
        chk("rst_haddr",  bus.HADDR, 32'h0);
        chk("rst_hwdata", bus.HWDATA, 32'h0);
        chk("rst_rdata",  bus.RDATA, 32'h0);
        chk("rst_err",    32'(bus.ERR), 32'h0);
        chk("rst_hwrite", 32'(bus.HWRITE), 32'h0);
      end else begin
        e_grant = m_busy ? onehot(m_owner) : '0;
        e_ack   = (m_busy && m_cyc == 3 + m_w) ? onehot(m_owner) : '0;
        e_hsel  = m_busy && (m_cyc == 1);
        if (m_busy && m_cyc == 3 + m_w) begin
          if (!m_hwrite) m_rdata = slv_rdata;
          m_err = slv_err;
        end
        chk("grant",  32'(bus.GRANT), 32'(e_grant));
        chk("ack",    32'(bus.ACK), 32'(e_ack));
        chk("hsel",   32'(bus.HSEL), 32'(e_hsel));
        chk("htrans", 32'(bus.HTRANS), e_hsel ? 32'h2 : 32'h0);
        chk("haddr",  bus.HADDR, m_haddr);
        chk("hwrite", 32'(bus.HWRITE), 32'(m_hwrite));
        chk("hwdata", bus.HWDATA, m_hwdata);
        chk("rdata",  bus.RDATA, m_rdata);
        chk("err",    32'(bus.ERR), 32'(m_err));
        for (int i = 0; i < NREQ; i++) begin
          if (bus.ACK[i]) begin
            ack_t a;
            a.idx = i; a.cyc = cyc; a.err = bus.ERR; a.rdata = bus.RDATA;
            a.haddr = bus.HADDR; a.hwdata = bus.HWDATA;
            alog.push_back(a);
          end
        end
        if (!m_busy) begin
          for (int k = 1; k <= NREQ; k++) begin
            int j;
            j = (m_last + k) % NREQ;
            if (!m_busy && bus.REQ[j]) begin
              m_busy = 1; m_owner = j; m_last = j; m_cyc = 1; m_w = slv_wait;
              m_haddr  = bus.REQ_ADDR[32*j +: 32];
              m_hwdata = bus.REQ_WDATA[32*j +: 32];
              m_hwrite = bus.REQ_WRITE[j];
            end
          end
        end else if (m_cyc == 3 + m_w) begin
          m_busy = 0;
        end else begin
          m_cyc++;
        end
      end
    end
  end

  task automatic wait_acks(input int n, input int budget);
    int k;
    k = 0;
    while (alog.size() < n && k < budget) begin
      @(posedge HCLK);
      k++;
    end
    chk("ack_count", 32'(alog.size()), 32'(n));
    repeat (3) @(posedge HCLK);
    #1;
  endtask

  task automatic do_reset();
    HRESET = 1'b1;
    for (int i = 0; i < NREQ; i++) pend[i].delete();
    repeat (3) @(posedge HCLK);
    #1;
    HRESET = 1'b0;
    repeat (2) @(posedge HCLK);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int b;
    int ord[$];
    HRESET = 1'b1;
    repeat (3) @(posedge HCLK);
    #1;
    chk("init_grant",  32'(bus.GRANT), 32'h0);
    chk("init_htrans", 32'(bus.HTRANS), 32'h0);
    chk("init_hprot",  32'(bus.HPROT), 32'h3);
    HRESET = 1'b0;
    repeat (2) @(posedge HCLK);
    #1;

    // single write from requester 0, one wait state
    slv_wait = 1; slv_err = 1'b0; slv_rdata = 32'h0;
    b = alog.size();
    enq(0, 1'b1, 32'h0100_0004, 32'hA5A5_5A5A);
    wait_acks(b + 1, 60);
    if (alog.size() > b) begin
      chk("wr_idx",    32'(alog[b].idx), 32'd0);
      chk("wr_lat",    32'(alog[b].cyc - req_t[0]), 32'd4);
      chk("wr_err",    32'(alog[b].err), 32'h0);
      chk("wr_haddr",  alog[b].haddr, 32'h0100_0004);
      chk("wr_hwdata", alog[b].hwdata, 32'hA5A5_5A5A);
    end

    // single read from requester 2
    slv_rdata = 32'h1234_5678;
    b = alog.size();
    enq(2, 1'b0, 32'h0100_0010, 32'h0);
    wait_acks(b + 1, 60);
    if (alog.size() > b) begin
      chk("rd_idx",   32'(alog[b].idx), 32'd2);
      chk("rd_rdata", alog[b].rdata, 32'h1234_5678);
      chk("rd_lat",   32'(alog[b].cyc - req_t[2]), 32'd4);
    end

    // all four requesters from reset, two rounds
    do_reset();
    slv_rdata = 32'hCAFE_F00D;
    b = alog.size();
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < NREQ; i++)
        enq(i, 1'(r ^ (i & 1)), 32'h2000_0000 + 32'(i * 16 + r * 4), 32'h1111_0000 + 32'(i * 2 + r));
    wait_acks(b + 8, 200);
    ord = '{0, 1, 2, 3, 0, 1, 2, 3};
    if (alog.size() >= b + 8)
      for (int k = 0; k < 8; k++) begin
        chk("rr_order", 32'(alog[b + k].idx), 32'(ord[k]));
        if (k > 0) chk("rr_norepeat", 32'(alog[b + k].idx == alog[b + k - 1].idx), 32'h0);
      end

    // fairness after service: 2 alone, then 1 and 3 together
    b = alog.size();
    enq(2, 1'b1, 32'h3000_0000, 32'hDEAD_0002);
    wait_acks(b + 1, 60);
    enq(1, 1'b1, 32'h3000_0004, 32'hDEAD_0001);
    enq(3, 1'b0, 32'h3000_0008, 32'h0);
    wait_acks(b + 3, 100);
    if (alog.size() >= b + 3) begin
      chk("fair_first",  32'(alog[b + 1].idx), 32'd3);
      chk("fair_second", 32'(alog[b + 2].idx), 32'd1);
    end

    // error response, then a clean transfer
    slv_err = 1'b1; slv_wait = 1;
    b = alog.size();
    enq(1, 1'b1, 32'h0100_0008, 32'h0BAD_0001);
    wait_acks(b + 1, 60);
    if (alog.size() > b) begin
      chk("err_set", 32'(alog[b].err), 32'h1);
      chk("err_lat", 32'(alog[b].cyc - req_t[1]), 32'd4);
    end
    slv_err = 1'b0; slv_rdata = 32'h7777_8888;
    enq(1, 1'b0, 32'h0100_000C, 32'h0);
    wait_acks(b + 2, 60);
    if (alog.size() > b + 1) begin
      chk("err_clr",  32'(alog[b + 1].err), 32'h0);
      chk("err_rdat", alog[b + 1].rdata, 32'h7777_8888);
    end

    // reset during a long data phase
    slv_wait = 3;
    b = alog.size();
    enq(0, 1'b1, 32'h0400_0000, 32'h5555_AAAA);
    begin
      int k;
      k = 0;
      while (!bus.HSEL && k < 40) begin
        @(negedge HCLK);
        k++;
      end
      chk("abort_addr_seen", 32'(bus.HSEL), 32'h1);
    end
    @(posedge HCLK); #1;
    @(posedge HCLK); #1;
    HRESET = 1'b1;
    for (int i = 0; i < NREQ; i++) pend[i].delete();
    #1;
    chk("abort_grant",  32'(bus.GRANT), 32'h0);
    chk("abort_hsel",   32'(bus.HSEL), 32'h0);
    chk("abort_haddr",  bus.HADDR, 32'h0);
    chk("abort_hwdata", bus.HWDATA, 32'h0);
    chk("abort_rdata",  bus.RDATA, 32'h0);
    chk("abort_ack",    32'(bus.ACK), 32'h0);
    repeat (3) @(posedge HCLK);
    #1;
    HRESET = 1'b0;
    slv_wait = 1;
    repeat (2) @(posedge HCLK);
    #1;
    chk("abort_no_ack", 32'(alog.size()), 32'(b));
    enq(1, 1'b1, 32'h0400_0004, 32'h0000_0001);
    enq(0, 1'b1, 32'h0400_0008, 32'h0000_0000);
    wait_acks(b + 2, 100);
    if (alog.size() >= b + 2) begin
      chk("post_rst_first",  32'(alog[b].idx), 32'd0);
      chk("post_rst_second", 32'(alog[b + 1].idx), 32'd1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
